// File: rtl/button_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_pkg: shared FSM state encoding and counter sizing helper       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package button_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        DISARMING = 2'd3
    } state_t;

    // Bits needed to hold the values 0..max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff: two-flop synchronizer with a parameterized reset level      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | button_conditioner: debounces a raw button into a level plus          |
// | press/release pulses; BTN_LONG_PRESS_EN adds a long_press pulse.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module button_conditioner
    import button_pkg::*;
#(
    parameter int STABLE_COUNT = 4,
    parameter int ACTIVE_LOW   = 1
`ifdef BTN_LONG_PRESS_EN
    ,
    parameter int LONG_COUNT   = 32
`endif
) (
    input  logic clk,
    input  logic rst_btn,
    input  logic clk_enable,
    input  logic btn_in,
    output logic pressed,
    output logic press,
    output logic release_pulse
`ifdef BTN_LONG_PRESS_EN
    ,
    output logic long_press
`endif
);

    localparam int               CNT_W    = cnt_width(STABLE_COUNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
    localparam logic             PIN_IDLE = (ACTIVE_LOW != 0);

    logic             sync_q;
    logic             raw_act;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             pressed_nx, press_nx, release_nx;

    sync_2ff #(
        .RESET_VAL (PIN_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_btn),
        .d     (btn_in),
        .q     (sync_q)
    );

    assign raw_act = sync_q ^ PIN_IDLE;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state         <= IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            pressed       <= pressed_nx;
            press         <= press_nx;
            release_pulse <= release_nx;
        end
    end

    // raw_act is tested before clk_enable, so a bounce on the qualifying tick aborts.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (raw_act) begin
                    state_nx = ARMING;
                    cnt_nx   = '0;
                end
            end
            ARMING: begin
                if (!raw_act) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (clk_enable) begin
                    if (cnt == CNT_LAST) begin
                        state_nx = HELD;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            HELD: begin
                if (!raw_act) begin
                    state_nx = DISARMING;
                    cnt_nx   = '0;
                end
            end
            DISARMING: begin
                if (raw_act) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (clk_enable) begin
                    if (cnt == CNT_LAST) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        pressed_nx = (state_nx == HELD) || (state_nx == DISARMING);
        press_nx   = (state == ARMING) && (state_nx == HELD);
        release_nx = (state == DISARMING) && (state_nx == IDLE);
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int                LONG_W    = cnt_width(LONG_COUNT);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_COUNT - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_COUNT);

    logic [LONG_W-1:0] long_cnt;

    // Counter parks at LONG_COUNT so the pulse fires once per hold.
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            long_cnt   <= '0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (state != HELD) begin
                long_cnt <= '0;
            end else if (clk_enable && (long_cnt != LONG_MAX)) begin
                long_cnt   <= long_cnt + LONG_W'(1);
                long_press <= (long_cnt == LONG_LAST);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side counterpart to the LED/counter output chain.
- Takes a raw, bouncy, active-low board button (e.g. go_btn) and produces:
  - a clean debounced level;
  - single-cycle press and release pulses, usable as count_machine start inputs.
- Paced by the same clock_divider tick (clk_enable) as the counters.
- Sits between the board pin and any start/auto_start consumer in top.

Parameters:
- STABLE_COUNT, default 4: number of consecutive sample ticks the synchronized input must hold a new value before it is accepted; legal range 1..255.
- ACTIVE_LOW, default 1: 1 means raw pin reads 0 when pressed; 0 means pin reads 1 when pressed.

Ports:
- clk  input  1  system clock (12 MHz on icestick).
- rst_btn  input  1  asynchronous, active-low reset; all flops clear immediately on 0, release synchronous to clk.
- clk_enable  input  1  one-cycle sample tick from clock_divider.
- btn_in  input  1  raw asynchronous button pin.
- pressed  output  1  debounced level, 1 = button held.
- press  output  1  one-clk pulse when pressed rises.
- release  output  1  one-clk pulse when pressed falls.

Behaviour:
- Synchronizer: 2-flop chain on btn_in, every clk (not gated by clk_enable).
  - Reset value of both flops is the inactive pin level: 1 if ACTIVE_LOW, else 0.
  - raw_act = sync2 XOR ACTIVE_LOW, so 1 = pressed.
- Counter: cnt, width CNT_W = $clog2(STABLE_COUNT+1), reset 0.
- FSM states: IDLE, ARMING, HELD, DISARMING; reset state IDLE.
  - IDLE: raw_act=1 → ARMING, cnt=0.
  - ARMING:
    - raw_act=0 → IDLE, cnt=0, no pulse (bounce rejected).
    - raw_act=1 and clk_enable and cnt==STABLE_COUNT-1 → HELD.
    - raw_act=1 and clk_enable otherwise → cnt++.
    - no clk_enable → hold.
  - HELD: mirror of IDLE; raw_act=0 → DISARMING, cnt=0.
  - DISARMING: mirror of ARMING with polarity inverted; completes to IDLE.
- Outputs are registered.
  - pressed is 1 exactly in HELD and DISARMING.
  - press is 1 for the single clk following the ARMING→HELD transition edge, coincident with pressed first reading 1.
  - release likewise on the DISARMING→IDLE edge, coincident with pressed first reading 0.
  - press and release are never both 1.
- Reset values: pressed=0, press=0, release=0, cnt=0, state IDLE.
- Latency:
  - 2 clk synchronizer + 1 clk to enter ARMING + STABLE_COUNT accepted ticks + 1 register stage.
  - A clean press is reported on the clk after the STABLE_COUNT-th tick seen while in ARMING.
- Boundary conditions:
  - STABLE_COUNT=1: accept on first tick in ARMING/DISARMING.
  - A raw_act toggle in the same clk as the qualifying clk_enable: raw_act is evaluated first, so the transition aborts.
  - cnt never wraps; it saturates logically because the state leaves ARMING/DISARMING at the terminal count.
  - Button held across reset deassertion: FSM starts IDLE, sees raw_act=1 after sync, debounces, then emits press. A press pulse after reset is the intended behaviour.
  - Reset mid-pulse: pulse truncated immediately (async clear).

Optional Feature:
- Macro BTN_LONG_PRESS_EN.
- When defined:
  - Adds parameter LONG_COUNT (default 32) and output port long_press (1 bit).
  - A second counter (reset 0) increments on clk_enable while in HELD.
  - Reaching LONG_COUNT emits a one-clk long_press pulse.
  - The counter then saturates until HELD is exited, where it clears.
  - long_press fires at most once per hold and is reset to 0.
- When undefined: no port, no counter, no extra logic.

Decomposition:
- Shared package (button_pkg) holds:
  - FSM state encoding: IDLE=2'd0, ARMING=2'd1, HELD=2'd2, DISARMING=2'd3.
  - Helper constant for CNT_W derivation.
- One natural sub-module, sync_2ff: 2-flop synchronizer with parameterized reset value, reusable for rst_btn and other pins.

Test Plan:
All scenarios use STABLE_COUNT=4, clk_enable every 10 clk.
- Clean press: btn_in held 0 for 100 clk → press high for exactly 1 clk roughly 40 clk after the first sync'd 0; pressed=1 thereafter; release never fires.
- Bounce rejection: btn_in toggles 0/1 every 7 clk for 200 clk, then rests at 1 → press, release, and pressed all stay 0 throughout.
- Clean release: from HELD, btn_in=1 for 60 clk → release pulse of 1 clk; pressed falls in the same clk; press stays 0.
- Async reset mid-hold: in HELD, pull rst_btn=0 for 3 clk → pressed/press/release read 0 within that clk; with btn_in still 0, a new press pulse appears about 4 ticks after reset release.
- STABLE_COUNT=1 variant: a single tick with the button pressed → press asserts on the clk after that tick.
- BTN_LONG_PRESS_EN with LONG_COUNT=8: hold 20 ticks → exactly one long_press pulse on the clk after the 8th tick in HELD; release and re-hold 20 ticks → a second single pulse.
